// File: rtl/sfq_stage_counter_cmp.sv
// Staged WIDTH-bit enabled up counter with load, equality compare (Z), sticky HIT and terminal count.
// Optional macro CMP_PIPE_EN: per-stage match registers feed Z, giving a 2-cycle compare latency.
module sfq_stage_counter_cmp #(
  parameter int WIDTH = 16,
  parameter int STAGE = 4
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic [WIDTH-1:0] C,
  input  logic             CLR_HIT,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Z,
  output logic             HIT
);

  localparam int NS = WIDTH / STAGE;

  logic [NS-1:0]    stage_ones;
  logic [NS-1:0]    stage_en;
  logic [WIDTH-1:0] q_next;
  logic             z_d;

  if ((WIDTH % STAGE) != 0 || WIDTH < 4 || WIDTH > 64 || STAGE < 2 || STAGE > 8) begin : g_bad_params
    $error("sfq_stage_counter_cmp: illegal WIDTH/STAGE combination");
  end

  // Each stage's enable is a flat AND of EN and all lower stage all-ones flags,
  // so carries resolve within one cycle and fan-in per stage stays bounded.
  for (genvar s = 0; s < NS; s++) begin : g_stage
    logic [STAGE-1:0] nxt;

    assign stage_ones[s] = &Q[s*STAGE +: STAGE];

    if (s == 0) begin : g_first
      assign stage_en[s] = EN;
    end else begin : g_upper
      assign stage_en[s] = EN & (&stage_ones[s-1:0]);
    end

    always_comb begin
      nxt = Q[s*STAGE +: STAGE];
      if (LOAD) begin
        nxt = LOAD_VAL[s*STAGE +: STAGE];
      end else if (stage_en[s]) begin
        nxt = Q[s*STAGE +: STAGE] + STAGE'(1);
      end
    end

    assign q_next[s*STAGE +: STAGE] = nxt;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      Q <= '0;
    end else begin
      Q <= q_next;
    end
  end

  assign TC = EN & ~LOAD & (&Q);

`ifdef CMP_PIPE_EN
  logic [NS-1:0] stage_match;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      stage_match <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        stage_match[i] <= EN & (Q[i*STAGE +: STAGE] == C[i*STAGE +: STAGE]);
      end
    end
  end

  assign z_d = &stage_match;
`else
  assign z_d = EN & (Q == C);
`endif

  // A compare hit on the same edge as CLR_HIT keeps HIT set.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      Z   <= 1'b0;
      HIT <= 1'b0;
    end else begin
      Z <= z_d;
      if (z_d) begin
        HIT <= 1'b1;
      end else if (CLR_HIT) begin
        HIT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sfq_stage_counter_cmp.sv
// Directed bench for sfq_stage_counter_cmp: 16/4 instance for function, 8/2 instance for a full wrap sweep.
module tb_sfq_stage_counter_cmp;

  logic        ck = 1'b0;
  logic        rst;
  logic        en, load, clr;
  logic [15:0] lv, c;
  logic [15:0] q;
  logic        tc, z, hit;

  logic        en2, load2, clr2;
  logic [7:0]  lv2, c2;
  logic [7:0]  q2;
  logic        tc2, z2, hit2;

  int n_assert = 0;
  int n_fail   = 0;
  int tc_cnt   = 0;
  int z_cnt    = 0;

  always #5 ck = ~ck;

  sfq_stage_counter_cmp #(.WIDTH(16), .STAGE(4)) dut (
    .CK(ck), .RST(rst), .EN(en), .LOAD(load), .LOAD_VAL(lv), .C(c),
    .CLR_HIT(clr), .Q(q), .TC(tc), .Z(z), .HIT(hit)
  );

  sfq_stage_counter_cmp #(.WIDTH(8), .STAGE(2)) dut2 (
    .CK(ck), .RST(rst), .EN(en2), .LOAD(load2), .LOAD_VAL(lv2), .C(c2),
    .CLR_HIT(clr2), .Q(q2), .TC(tc2), .Z(z2), .HIT(hit2)
  );

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; clr = 1'b0; lv = '0; c = 16'h5a5a;
    en2 = 1'b0; load2 = 1'b0; clr2 = 1'b0; lv2 = '0; c2 = 8'h80;

    // reset state, EN high to show TC stays low under reset
    tick(); tick();
    check("rst_q", q, 0);
    check("rst_z", z, 0);
    check("rst_hit", hit, 0);
    check("rst_tc", tc, 0);
    check("rst_q2", q2, 0);
    rst = 1'b0; en = 1'b0;

    // count and carry
    load = 1'b1; lv = 16'h0fff; tick();
    check("load_0fff", q, 16'h0fff);
    load = 1'b0; en = 1'b1; tick();
    check("carry_1000", q, 16'h1000);
    en = 1'b0; load = 1'b1; lv = 16'hfffe; tick();
    check("load_fffe", q, 16'hfffe);
    load = 1'b0; en = 1'b1; #1;
    check("tc_fffe", tc, 0);
    tick();
    check("q_ffff", q, 16'hffff);
    check("tc_ffff", tc, 1);
    load = 1'b1; #1;
    check("tc_load_masks", tc, 0);
    load = 1'b0; #1;
    tick();
    check("wrap_q", q, 16'h0000);
    check("wrap_tc", tc, 0);
    en = 1'b0; #1;
    check("tc_en_low", tc, 0);
    check("no_hit_yet", hit, 0);

    // compare latency
    c = 16'h0005; load = 1'b1; lv = 16'h0005; tick();
    check("cmp_load_q", q, 5);
    check("cmp_load_z", z, 0);
    load = 1'b0; en = 1'b1; tick();
    check("cmp_q_inc", q, 6);
`ifdef CMP_PIPE_EN
    check("cmp_z_lat1", z, 0);
    check("cmp_hit_lat1", hit, 0);
    en = 1'b0; tick();
    check("cmp_z_lat2", z, 1);
    check("cmp_hit_lat2", hit, 1);
`else
    check("cmp_z_lat1", z, 1);
    check("cmp_hit_lat1", hit, 1);
    en = 1'b0; tick();
    check("cmp_z_lat2", z, 0);
    check("cmp_hit_lat2", hit, 1);
`endif
    tick();
    check("cmp_z_settled", z, 0);
    check("cmp_hit_sticky", hit, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_hit", hit, 0);

    // match with EN low never raises Z
    load = 1'b1; lv = 16'h0005; tick();
    load = 1'b0; tick(); tick();
    check("en0_q", q, 5);
    check("en0_z", z, 0);
    check("en0_hit", hit, 0);

    // priority: LOAD beats EN, compare uses pre-load Q, set beats clear
    c = 16'h0001; load = 1'b1; lv = 16'h0001; tick();
    check("prio_pre_q", q, 1);
    lv = 16'habcd; en = 1'b1; clr = 1'b1; tick();
    check("prio_load_q", q, 16'habcd);
`ifdef CMP_PIPE_EN
    check("prio_a_z", z, 0);
    check("prio_a_hit", hit, 0);
`else
    check("prio_a_z", z, 1);
    check("prio_a_hit", hit, 1);
`endif
    load = 1'b0; en = 1'b0; c = 16'h5a5a; tick();
    check("prio_b_q", q, 16'habcd);
`ifdef CMP_PIPE_EN
    check("prio_b_z", z, 1);
    check("prio_b_hit", hit, 1);
`else
    check("prio_b_z", z, 0);
    check("prio_b_hit", hit, 0);
`endif
    tick();
    check("prio_c_hit", hit, 0);
    clr = 1'b0;

    // hold with C equal to Q and EN low
    c = 16'h7777; load = 1'b1; lv = 16'h7777; tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_q", q, 16'h7777);
      check("hold_tc", tc, 0);
      check("hold_z", z, 0);
    end

    // reset mid-count
    load = 1'b1; lv = 16'h1234; tick();
    load = 1'b0; en = 1'b1; c = 16'h1234; tick(); tick();
    check("mid_q", q, 16'h1236);
    check("mid_hit", hit, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_z", z, 0);
    check("mid_rst_hit", hit, 0);
    check("mid_rst_tc", tc, 0);
    tick(); tick();
    check("mid_rst_hold_q", q, 0);
    rst = 1'b0;
    tick();
    check("post_rst_q", q, 1);
    check("post_rst_z", z, 0);
    en = 1'b0;

    // 8-bit / 2-bit-stage full wrap sweep
    en2 = 1'b1; #1;
    for (int i = 0; i < 256; i++) begin
      if (tc2) tc_cnt++;
      if (z2) z_cnt++;
      tick();
    end
    en2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (z2) z_cnt++;
      tick();
    end
    check("sweep_q2", q2, 0);
    check("sweep_tc_pulses", tc_cnt, 1);
    check("sweep_z_pulses", z_cnt, 1);
    check("sweep_hit2", hit2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sfq_stage_counter_cmp.md
Name: sfq_stage_counter_cmp

Overview:
- Parametrised successor to the fixed 16-bit, 4-bit-stage enabled counter/comparator benchmark.
- WIDTH-bit synchronous up counter built from STAGE-bit stages with per-stage carry enables, plus load, registered equality compare against C, a sticky hit flag and a terminal-count strobe.
- Used as a scalable SFQ benchmark core: the same counter/compare function at any width, with explicit stage structure so splitter fan-out stays bounded per stage.

Parameters:
- WIDTH, 16, counter and compare width in bits; must be a multiple of STAGE, legal range 4..64.
- STAGE, 4, bits per counter stage; 2..8.

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  count enable (the P_0 role).
- LOAD  input  1  synchronous load of LOAD_VAL into the counter.
- LOAD_VAL  input  WIDTH  load value.
- C  input  WIDTH  compare value.
- CLR_HIT  input  1  synchronous clear of HIT.
- Q  output  WIDTH  counter state.
- TC  output  1  combinational terminal count, = EN & ~LOAD & (Q == all ones).
- Z  output  1  registered compare result.
- HIT  output  1  sticky compare flag.

Behaviour:
- Reset: RST high asynchronously forces Q=0, Z=0, HIT=0, and all internal pipeline registers to 0. TC therefore reads 0 while RST is high.
- After RST falls, the first rising CK edge behaves normally.
- Update priority per edge: LOAD > EN > hold.
  - LOAD=1: Q <= LOAD_VAL, regardless of EN.
  - LOAD=0, EN=1: Q <= Q+1 modulo 2^WIDTH.
  - Otherwise Q holds.
- Stage structure, STAGE-wide stages s=0..WIDTH/STAGE-1:
  - Stage s increments only when EN=1 and all lower stages are all ones (lookahead carry, single-cycle, no ripple delay across edges).
  - Q bits of stage s are Q[s*STAGE +: STAGE].
- Wrap-around: from all ones with EN=1, Q -> 0 on the next edge. TC=1 during the cycle before the wrap.
- Compare, latency 1:
  - Z <= EN & (Q == C), using the pre-edge Q and C.
  - Z is low in any cycle following EN=0, even if Q==C.
  - LOAD does not suppress Z; the compare uses the pre-load Q.
- HIT:
  - Sets on any edge where the Z register input is 1.
  - Cleared by CLR_HIT=1.
  - Set and clear on the same edge: set wins, HIT=1.
  - Stays 1 otherwise until RST.
- C changes mid-operation: take effect on the next edge, with no filtering.
- RST asserted mid-count: immediate clear of all state. No partial stage update survives.
- The counter must never enter an illegal state; every 2^WIDTH value is legal.

Optional Feature:
- Macro CMP_PIPE_EN.
- Defined:
  - The compare is split into per-stage equality registers (stage match & EN captured at edge n), then ANDed into Z at edge n+1. Z latency is 2 cycles.
  - HIT follows the final Z-register input, so it is also 2 cycles behind the compare.
  - Purpose: path balancing for SFQ; all comparator gates fan in at most STAGE bits before a register.
- Not defined: single-register Z, latency 1, as above.
- Q, TC and LOAD behaviour are identical in both builds.

Test Plan (WIDTH=16, STAGE=4 unless noted):
- Reset mid-count: Q=0x1234, assert RST between edges -> Q=0, Z=0, HIT=0 immediately; hold RST for 2 edges -> Q stays 0.
- Count and carry: LOAD 0x0FFF, then EN=1 for 1 edge -> Q=0x1000. LOAD 0xFFFE, EN=1 -> TC=0, edge -> Q=0xFFFF, TC=1, edge -> Q=0x0000, TC=0.
- Compare latency: C=0x0005, Q=0x0005 with EN=1, edge -> Z=1, HIT=1. With EN=0 on that edge instead -> Z=0, HIT unchanged. With CMP_PIPE_EN, Z=1 appears one edge later.
- Priority: LOAD=1, EN=1, LOAD_VAL=0xABCD at Q=0x0001 -> Q=0xABCD, not 0x0002. CLR_HIT=1 on an edge where Z input=1 -> HIT=1.
- Hold: EN=0, LOAD=0 for 10 edges at Q=0x7777 -> Q unchanged, TC=0, Z=0.
- Width sweep: WIDTH=8, STAGE=2, 256 EN edges from 0 -> Q returns to 0x00, TC pulses exactly once, C=0x80 gives exactly one Z pulse.
